// File: rtl/el2_ifu_i0_issue_q_if.sv
// Aligner-to-decode i0 channel: fetch packet inputs, queue head outputs and the decode consume strobe.
// The environment (fetch + decode) takes master; the issue queue takes slave.
interface el2_ifu_i0_issue_q_if #(
    parameter int BTB_IDX_W = 8,
    parameter int GHR_W     = 8
);
    logic                 fe_valid;
    logic                 fe_ready;
    logic [31:0]          fe_instr;
    logic [30:0]          fe_pc;
    logic                 fe_icaf;
    logic [1:0]           fe_icaf_type;
    logic                 fe_icaf_second;
    logic                 fe_dbecc;
    logic                 fe_brp_valid;
    logic [11:0]          fe_brp_toffset;
    logic [1:0]           fe_brp_hist;
    logic                 fe_brp_ret;
    logic [BTB_IDX_W-1:0] fe_bp_index;
    logic [GHR_W-1:0]     fe_bp_fghr;

    logic                 dec_i0_decode_d;

    logic                 ifu_i0_valid;
    logic [31:0]          ifu_i0_instr;
    logic [30:0]          ifu_i0_pc;
    logic                 ifu_i0_pc4;
    logic                 ifu_i0_icaf;
    logic [1:0]           ifu_i0_icaf_type;
    logic                 ifu_i0_icaf_second;
    logic                 ifu_i0_dbecc;
    logic                 i0_brp_valid;
    logic [11:0]          i0_brp_toffset;
    logic [1:0]           i0_brp_hist;
    logic                 i0_brp_ret;
    logic [BTB_IDX_W-1:0] ifu_i0_bp_index;
    logic [GHR_W-1:0]     ifu_i0_bp_fghr;

    modport master (
        output fe_valid, fe_instr, fe_pc, fe_icaf, fe_icaf_type, fe_icaf_second, fe_dbecc,
               fe_brp_valid, fe_brp_toffset, fe_brp_hist, fe_brp_ret, fe_bp_index, fe_bp_fghr,
               dec_i0_decode_d,
        input  fe_ready,
               ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf, ifu_i0_icaf_type,
               ifu_i0_icaf_second, ifu_i0_dbecc, i0_brp_valid, i0_brp_toffset, i0_brp_hist,
               i0_brp_ret, ifu_i0_bp_index, ifu_i0_bp_fghr
    );

    modport slave (
        input  fe_valid, fe_instr, fe_pc, fe_icaf, fe_icaf_type, fe_icaf_second, fe_dbecc,
               fe_brp_valid, fe_brp_toffset, fe_brp_hist, fe_brp_ret, fe_bp_index, fe_bp_fghr,
               dec_i0_decode_d,
        output fe_ready,
               ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf, ifu_i0_icaf_type,
               ifu_i0_icaf_second, ifu_i0_dbecc, i0_brp_valid, i0_brp_toffset, i0_brp_hist,
               i0_brp_ret, ifu_i0_bp_index, ifu_i0_bp_fghr
    );
endinterface

// File: rtl/el2_ifu_i0_issue_q.sv
// i0 issue queue: small circular FIFO of fetched packets, head presented to decode,
// retired on decode, emptied on pipeline flush.
module el2_ifu_i0_issue_q #(
    parameter int DEPTH     = 4,
    parameter int BTB_IDX_W = 8,
    parameter int GHR_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    el2_ifu_i0_issue_q_if.slave        io,
    input  logic                       exu_flush_final,
    output logic [$clog2(DEPTH+1)-1:0] iq_count,
    output logic                       iq_err_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]          instr;
        logic [30:0]          pc;
        logic                 pc4;
        logic                 icaf;
        logic [1:0]           icaf_type;
        logic                 icaf_second;
        logic                 dbecc;
        logic                 brp_valid;
        logic [11:0]          brp_toffset;
        logic [1:0]           brp_hist;
        logic                 brp_ret;
        logic [BTB_IDX_W-1:0] bp_index;
        logic [GHR_W-1:0]     bp_fghr;
    } entry_t;

    entry_t        entry_q [DEPTH];
    entry_t        wr_entry;
    entry_t        head;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;

    logic          i0_valid;
    logic          fe_ready;
    logic          enq;
    logic          deq;

    // Ready looks only at registered occupancy, so a full queue never takes a packet
    // even when decode frees a slot in the same cycle.
    assign i0_valid = (count_q != '0);
    assign fe_ready = (count_q < CW'(DEPTH));
    assign enq      = io.fe_valid & fe_ready & ~exu_flush_final;
    assign deq      = io.dec_i0_decode_d & i0_valid & ~exu_flush_final;

    always_comb begin
        wr_entry             = '0;
        wr_entry.instr       = io.fe_instr;
        wr_entry.pc          = io.fe_pc;
        wr_entry.pc4         = (io.fe_instr[1:0] == 2'b11);
        wr_entry.icaf        = io.fe_icaf;
        wr_entry.icaf_type   = io.fe_icaf_type;
        wr_entry.icaf_second = io.fe_icaf_second;
        wr_entry.dbecc       = io.fe_dbecc;
        wr_entry.brp_valid   = io.fe_brp_valid;
        wr_entry.brp_toffset = io.fe_brp_toffset;
        wr_entry.brp_hist    = io.fe_brp_hist;
        wr_entry.brp_ret     = io.fe_brp_ret;
        wr_entry.bp_index    = io.fe_bp_index;
        wr_entry.bp_fghr     = io.fe_bp_fghr;
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q | (io.dec_i0_decode_d & ~i0_valid);

        if (exu_flush_final) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (enq) entry_q[wr_ptr_q] <= wr_entry;
    end

    assign head = entry_q[rd_ptr_q];

    assign io.fe_ready           = fe_ready;
    assign io.ifu_i0_valid       = i0_valid;
    assign io.ifu_i0_instr       = head.instr;
    assign io.ifu_i0_pc          = head.pc;
    assign io.ifu_i0_pc4         = head.pc4;
    assign io.ifu_i0_icaf        = head.icaf;
    assign io.ifu_i0_icaf_type   = head.icaf_type;
    assign io.ifu_i0_icaf_second = head.icaf_second;
    assign io.ifu_i0_dbecc       = head.dbecc;
    assign io.i0_brp_valid       = head.brp_valid;
    assign io.i0_brp_toffset     = head.brp_toffset;
    assign io.i0_brp_hist        = head.brp_hist;
    assign io.i0_brp_ret         = head.brp_ret;
    assign io.ifu_i0_bp_index    = head.bp_index;
    assign io.ifu_i0_bp_fghr     = head.bp_fghr;

    assign iq_count         = count_q;
    assign iq_err_underflow = underflow_q;

endmodule

// File: tb/tb_el2_ifu_i0_issue_q.sv
// Directed bench for el2_ifu_i0_issue_q: a queue-based packet model checked every cycle,
// plus literal expectations for the reset, single-packet, full, streaming, flush and underflow cases.
module tb_el2_ifu_i0_issue_q;
    localparam int DEPTH     = 4;
    localparam int BTB_IDX_W = 8;
    localparam int GHR_W     = 8;

    typedef struct packed {
        logic [31:0]          instr;
        logic [30:0]          pc;
        logic                 icaf;
        logic [1:0]           icaf_type;
        logic                 icaf_second;
        logic                 dbecc;
        logic                 brp_valid;
        logic [11:0]          toffset;
        logic [1:0]           hist;
        logic                 ret;
        logic [BTB_IDX_W-1:0] bp_index;
        logic [GHR_W-1:0]     fghr;
    } pkt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       exu_flush_final = 1'b0;
    logic [2:0] iq_count;
    logic       iq_err_underflow;

    el2_ifu_i0_issue_q_if #(.BTB_IDX_W(BTB_IDX_W), .GHR_W(GHR_W)) io ();

    el2_ifu_i0_issue_q #(.DEPTH(DEPTH), .BTB_IDX_W(BTB_IDX_W), .GHR_W(GHR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .io               (io),
        .exu_flush_final  (exu_flush_final),
        .iq_count         (iq_count),
        .iq_err_underflow (iq_err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic pkt_t mk(input logic [31:0] instr, input int id);
        pkt_t p;
        p.instr       = instr;
        p.pc          = 31'h40 + 31'(id * 2);
        p.icaf        = id[0];
        p.icaf_type   = id[2:1];
        p.icaf_second = id[1];
        p.dbecc       = id[2];
        p.brp_valid   = id[0] ^ id[1];
        p.toffset     = 12'(id * 37);
        p.hist        = id[1:0];
        p.ret         = id[3];
        p.bp_index    = BTB_IDX_W'(id * 5 + 1);
        p.fghr        = GHR_W'(~id);
        return p;
    endfunction

    task automatic drive(input pkt_t p, input logic v);
        io.fe_valid       = v;
        io.fe_instr       = p.instr;
        io.fe_pc          = p.pc;
        io.fe_icaf        = p.icaf;
        io.fe_icaf_type   = p.icaf_type;
        io.fe_icaf_second = p.icaf_second;
        io.fe_dbecc       = p.dbecc;
        io.fe_brp_valid   = p.brp_valid;
        io.fe_brp_toffset = p.toffset;
        io.fe_brp_hist    = p.hist;
        io.fe_brp_ret     = p.ret;
        io.fe_bp_index    = p.bp_index;
        io.fe_bp_fghr     = p.fghr;
    endtask

    function automatic pkt_t cur_pkt();
        pkt_t p;
        p.instr       = io.fe_instr;
        p.pc          = io.fe_pc;
        p.icaf        = io.fe_icaf;
        p.icaf_type   = io.fe_icaf_type;
        p.icaf_second = io.fe_icaf_second;
        p.dbecc       = io.fe_dbecc;
        p.brp_valid   = io.fe_brp_valid;
        p.toffset     = io.fe_brp_toffset;
        p.hist        = io.fe_brp_hist;
        p.ret         = io.fe_brp_ret;
        p.bp_index    = io.fe_bp_index;
        p.fghr        = io.fe_bp_fghr;
        return p;
    endfunction

    function automatic logic [127:0] head_exp(input pkt_t p);
        logic is4;
        is4 = (p.instr[1:0] == 2'b11) ? 1'b1 : 1'b0;
        return 128'({p.instr, p.pc, is4, p.icaf, p.icaf_type, p.icaf_second, p.dbecc,
                     p.brp_valid, p.toffset, p.hist, p.ret, p.bp_index, p.fghr});
    endfunction

    function automatic logic [127:0] head_act();
        return 128'({io.ifu_i0_instr, io.ifu_i0_pc, io.ifu_i0_pc4, io.ifu_i0_icaf,
                     io.ifu_i0_icaf_type, io.ifu_i0_icaf_second, io.ifu_i0_dbecc,
                     io.i0_brp_valid, io.i0_brp_toffset, io.i0_brp_hist, io.i0_brp_ret,
                     io.ifu_i0_bp_index, io.ifu_i0_bp_fghr});
    endfunction

    // Model: a packet queue. Inputs change just after posedge and hold to the next one,
    // so at negedge the model first checks the DUT, then applies the upcoming edge.
    pkt_t mq[$];
    bit   m_err   = 1'b0;
    bit   m_known = 1'b0;
    bit   m_ready;
    always @(negedge clk) begin
        if (m_known) begin
            check("valid",     128'(io.ifu_i0_valid),   128'(mq.size() != 0));
            check("count",     128'(iq_count),          128'(mq.size()));
            check("fe_ready",  128'(io.fe_ready),       128'(mq.size() < DEPTH));
            check("underflow", 128'(iq_err_underflow),  128'(m_err));
            if (mq.size() != 0) check("head", head_act(), head_exp(mq[0]));
        end
        if (rst) begin
            mq.delete();
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            m_ready = (mq.size() < DEPTH);
            if (io.dec_i0_decode_d && mq.size() == 0) m_err = 1'b1;
            if (exu_flush_final) mq.delete();
            else begin
                if (io.dec_i0_decode_d && mq.size() != 0) void'(mq.pop_front());
                if (io.fe_valid && m_ready) mq.push_back(cur_pkt());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t3 [5] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

    initial begin
        io.dec_i0_decode_d = 1'b0;
        drive(mk(32'h0, 0), 1'b0);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_valid", 128'(io.ifu_i0_valid), 128'(0));
        check("rst_ready", 128'(io.fe_ready), 128'(1));
        check("rst_count", 128'(iq_count), 128'(0));

        // Idle after reset
        repeat (10) cycle();
        check("idle_valid", 128'(io.ifu_i0_valid), 128'(0));
        check("idle_count", 128'(iq_count), 128'(0));

        // Single packet, visible next cycle, gone after one decode
        drive(mk(32'h00000013, 0), 1'b1);
        cycle();
        drive(mk(32'h0, 0), 1'b0);
        check("t2_valid", 128'(io.ifu_i0_valid), 128'(1));
        check("t2_instr", 128'(io.ifu_i0_instr), 128'(32'h13));
        check("t2_pc",    128'(io.ifu_i0_pc),    128'(31'h40));
        check("t2_pc4",   128'(io.ifu_i0_pc4),   128'(1));
        io.dec_i0_decode_d = 1'b1;
        cycle();
        io.dec_i0_decode_d = 1'b0;
        check("t2_gone", 128'(io.ifu_i0_valid), 128'(0));

        // Fill to DEPTH, offer a 5th with decode, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(mk(t3[i], 10 + i), 1'b1);
            cycle();
        end
        check("t3_full_count", 128'(iq_count), 128'(4));
        check("t3_full_ready", 128'(io.fe_ready), 128'(0));
        drive(mk(t3[4], 14), 1'b1);
        io.dec_i0_decode_d = 1'b1;
        check("t3_head0", 128'(io.ifu_i0_instr), 128'(32'h00100093));
        cycle();
        drive(mk(32'h0, 0), 1'b0);
        check("t3_no5th_count", 128'(iq_count), 128'(3));
        check("t3_head1", 128'(io.ifu_i0_instr), 128'(32'h00200113));
        cycle();
        check("t3_head2", 128'(io.ifu_i0_instr), 128'(32'h00300193));
        cycle();
        check("t3_head3", 128'(io.ifu_i0_instr), 128'(32'h00400213));
        cycle();
        io.dec_i0_decode_d = 1'b0;
        check("t3_empty", 128'(io.ifu_i0_valid), 128'(0));

        // Streaming 2-byte packets through the pointer wrap
        drive(mk({16'h0000, 16'h4501}, 30), 1'b1);
        cycle();
        for (int i = 1; i <= 9; i++) begin
            drive(mk({16'(i), 16'h4501}, 30 + i), 1'b1);
            io.dec_i0_decode_d = 1'b1;
            check("t4_head",  128'(io.ifu_i0_instr), 128'({16'(i - 1), 16'h4501}));
            check("t4_count", 128'(iq_count), 128'(1));
            cycle();
        end
        drive(mk(32'h0, 0), 1'b0);
        io.dec_i0_decode_d = 1'b0;
        check("t4_last", 128'(io.ifu_i0_instr), 128'(32'h00094501));
        check("t4_pc4",  128'(io.ifu_i0_pc4), 128'(0));
        io.dec_i0_decode_d = 1'b1;
        cycle();
        io.dec_i0_decode_d = 1'b0;
        check("t4_drained", 128'(io.ifu_i0_valid), 128'(0));

        // Flush with a concurrent enqueue and decode
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h50000003 + 32'(i << 8), 20 + i), 1'b1);
            cycle();
        end
        drive(mk(32'hDEAD0003, 23), 1'b1);
        io.dec_i0_decode_d = 1'b1;
        exu_flush_final    = 1'b1;
        cycle();
        drive(mk(32'h0, 0), 1'b0);
        io.dec_i0_decode_d = 1'b0;
        exu_flush_final    = 1'b0;
        check("t5_count", 128'(iq_count), 128'(0));
        check("t5_valid", 128'(io.ifu_i0_valid), 128'(0));
        check("t5_ready", 128'(io.fe_ready), 128'(1));
        drive(mk(32'hCAFE0007, 24), 1'b1);
        cycle();
        drive(mk(32'h0, 0), 1'b0);
        check("t5_next_head", 128'(io.ifu_i0_instr), 128'(32'hCAFE0007));
        check("t5_next_count", 128'(iq_count), 128'(1));
        io.dec_i0_decode_d = 1'b1;
        cycle();
        io.dec_i0_decode_d = 1'b0;

        // Underflow is sticky until reset
        check("t6_pre", 128'(iq_err_underflow), 128'(0));
        io.dec_i0_decode_d = 1'b1;
        cycle();
        io.dec_i0_decode_d = 1'b0;
        check("t6_set", 128'(iq_err_underflow), 128'(1));
        repeat (3) cycle();
        check("t6_hold",  128'(iq_err_underflow), 128'(1));
        check("t6_count", 128'(iq_count), 128'(0));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_clear", 128'(iq_err_underflow), 128'(0));
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
